// File: rtl/mux32_arbiter.sv
// Two-requester round-robin arbiter driving a 32-bit 2:1 mux into a single-entry
// output register with valid/ready handshake and per-grant burst limiting.
module mux32_arbiter #(
  parameter int unsigned BURST_MAX = 4
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        req0,
  input  logic        req1,
  input  logic [31:0] data0,
  input  logic [31:0] data1,
  output logic        gnt0,
  output logic        gnt1,
  output logic        sel,
  output logic        ack0,
  output logic        ack1,
  output logic [31:0] out_data,
  output logic        out_valid,
  input  logic        out_ready
);

  localparam int unsigned DW = 32;
  localparam int unsigned CW = 4;

  // Encoding chosen so each grant output is a state register bit.
  typedef enum logic [1:0] {
    ST_IDLE = 2'b00,
    ST_G0   = 2'b01,
    ST_G1   = 2'b10
  } state_t;

  state_t          r_state;
  state_t          w_next_state;
  state_t          w_arb;
  logic            r_last;
  logic            r_sel;
  logic            r_out_valid;
  logic [DW-1:0]   r_out_data;
  logic [CW-1:0]   r_beat_cnt;
  logic [CW-1:0]   w_beat_cnt_nxt;
  logic [CW-1:0]   w_cnt_inc;
  logic            w_ack0;
  logic            w_ack1;
  logic            w_accept;
  logic            w_req_cur;
  logic            w_enter;
  logic [DW-1:0]   w_mux_data;

  // Accept only when the output slot is empty or being drained this cycle.
  assign w_ack0    = !reset && (r_state == ST_G0) && req0 && (!r_out_valid || out_ready);
  assign w_ack1    = !reset && (r_state == ST_G1) && req1 && (!r_out_valid || out_ready);
  assign w_accept  = w_ack0 | w_ack1;
  assign w_cnt_inc = r_beat_cnt + CW'(w_accept);
  assign w_mux_data = r_sel ? data1 : data0;

  // Round-robin pick: on a tie the requester that was not granted last wins.
  always_comb begin
    w_arb = ST_IDLE;
    if (req0 && req1) begin
      w_arb = r_last ? ST_G0 : ST_G1;
    end else if (req0) begin
      w_arb = ST_G0;
    end else if (req1) begin
      w_arb = ST_G1;
    end
  end

  always_comb begin
    w_next_state   = r_state;
    w_beat_cnt_nxt = r_beat_cnt;
    w_enter        = 1'b0;
    w_req_cur      = (r_state == ST_G1) ? req1 : req0;
    case (r_state)
      ST_IDLE: begin
        w_next_state   = w_arb;
        w_beat_cnt_nxt = '0;
        w_enter        = (w_arb != ST_IDLE);
      end
      ST_G0, ST_G1: begin
        if (!w_req_cur || (w_cnt_inc == CW'(BURST_MAX))) begin
          w_next_state   = w_arb;
          w_beat_cnt_nxt = '0;
          w_enter        = (w_arb != ST_IDLE);
        end else begin
          w_beat_cnt_nxt = w_cnt_inc;
        end
      end
      default: begin
        w_next_state   = ST_IDLE;
        w_beat_cnt_nxt = '0;
      end
    endcase
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_state <= ST_IDLE;
    end else begin
      r_state <= w_next_state;
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_beat_cnt <= '0;
      r_last     <= 1'b1;
      r_sel      <= 1'b0;
    end else begin
      r_beat_cnt <= w_beat_cnt_nxt;
      if (w_enter) begin
        r_last <= (w_next_state == ST_G1);
        r_sel  <= (w_next_state == ST_G1);
      end
    end
  end

  // Single-entry output slot; grant changes never touch it.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_out_valid <= 1'b0;
      r_out_data  <= '0;
    end else if (w_accept) begin
      r_out_valid <= 1'b1;
      r_out_data  <= w_mux_data;
    end else if (out_ready) begin
      r_out_valid <= 1'b0;
    end
  end

  assign gnt0      = r_state[0];
  assign gnt1      = r_state[1];
  assign sel       = r_sel;
  assign ack0      = w_ack0;
  assign ack1      = w_ack1;
  assign out_data  = r_out_data;
  assign out_valid = r_out_valid;

endmodule

// File: tb/tb_mux32_arbiter.sv
// Bench for mux32_arbiter: directed scenarios plus random traffic, all compared
// cycle by cycle against a behavioural arbiter/output-slot model.
module tb_mux32_arbiter;

  localparam int unsigned BURST = 4;

  logic        clk = 1'b0;
  logic        reset;
  logic        req0, req1;
  logic [31:0] data0, data1;
  logic        gnt0, gnt1, sel, ack0, ack1;
  logic [31:0] out_data;
  logic        out_valid;
  logic        out_ready;

  int n_checks = 0;
  int n_pass   = 0;

  // Model state: grant holder (-1 none, 0, 1), last grantee, beats this grant, output slot.
  int          m_owner;
  int          m_last;
  int          m_beats;
  int          m_sel;
  bit          m_ov;
  logic [31:0] m_od;
  bit          m_acc0, m_acc1;

  mux32_arbiter #(.BURST_MAX(BURST)) dut (
    .clk(clk), .reset(reset),
    .req0(req0), .req1(req1), .data0(data0), .data1(data1),
    .gnt0(gnt0), .gnt1(gnt1), .sel(sel), .ack0(ack0), .ack1(ack1),
    .out_data(out_data), .out_valid(out_valid), .out_ready(out_ready)
  );

  always #5 clk = ~clk;

  task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got === exp) n_pass++;
    else $display("FAIL %s: got %h expected %h (t=%0t)", tag, got, exp, $time);
  endtask

  task automatic model_reset();
    m_owner = -1; m_last = 1; m_beats = 0; m_sel = 0; m_ov = 0; m_od = '0;
    m_acc0 = 0; m_acc1 = 0;
  endtask

  task automatic model_arbitrate(input bit r0, input bit r1);
    int w;
    w = -1;
    if (r0 && r1) w = 1 - m_last;
    else if (r0)  w = 0;
    else if (r1)  w = 1;
    m_owner = w;
    m_beats = 0;
    if (w >= 0) begin
      m_last = w;
      m_sel  = w;
    end
  endtask

  task automatic model_step(input bit r0, input bit r1, input logic [31:0] d0,
                            input logic [31:0] d1, input bit rdy);
    bit owner_req, acc;
    owner_req = (m_owner == 0) ? r0 : (m_owner == 1) ? r1 : 1'b0;
    acc       = owner_req && (!m_ov || rdy);
    m_acc0    = acc && (m_owner == 0);
    m_acc1    = acc && (m_owner == 1);
    if (acc) begin
      m_od = (m_owner == 1) ? d1 : d0;
      m_ov = 1;
    end else if (rdy) begin
      m_ov = 0;
    end
    if (m_owner < 0 || !owner_req || (m_beats + int'(acc) == int'(BURST)))
      model_arbitrate(r0, r1);
    else
      m_beats = m_beats + int'(acc);
  endtask

  task automatic check_all();
    bit e0, e1;
    e0 = (m_owner == 0) && req0 && (!m_ov || out_ready);
    e1 = (m_owner == 1) && req1 && (!m_ov || out_ready);
    check_eq("gnt0",      32'(gnt0),      32'(m_owner == 0));
    check_eq("gnt1",      32'(gnt1),      32'(m_owner == 1));
    check_eq("sel",       32'(sel),       32'(m_sel));
    check_eq("ack0",      32'(ack0),      32'(e0));
    check_eq("ack1",      32'(ack1),      32'(e1));
    check_eq("out_valid", 32'(out_valid), 32'(m_ov));
    check_eq("out_data",  out_data,       m_od);
  endtask

  // Called just after a rising edge: drive, check mid-cycle, step model on next edge.
  task automatic cycle(input bit r0, input bit r1, input logic [31:0] d0,
                       input logic [31:0] d1, input bit rdy);
    req0 = r0; req1 = r1; data0 = d0; data1 = d1; out_ready = rdy;
    #4;
    check_all();
    @(posedge clk);
    #1;
    model_step(r0, r1, d0, d1, rdy);
  endtask

  task automatic async_reset_mid_cycle();
    req0 = 1'b1; req1 = 1'b1; out_ready = 1'b1;
    #2;
    reset = 1'b1;
    #1;
    check_eq("rst_gnt0",  32'(gnt0),      32'h0);
    check_eq("rst_gnt1",  32'(gnt1),      32'h0);
    check_eq("rst_sel",   32'(sel),       32'h0);
    check_eq("rst_ack0",  32'(ack0),      32'h0);
    check_eq("rst_ack1",  32'(ack1),      32'h0);
    check_eq("rst_valid", 32'(out_valid), 32'h0);
    check_eq("rst_data",  out_data,       32'h0);
    model_reset();
    @(posedge clk);
    #1;
    check_eq("rst_hold_gnt0", 32'(gnt0), 32'h0);
    reset = 1'b0;
  endtask

  initial begin
    logic [31:0] d0, d1;
    bit r0, r1, rdy;
    reset = 1'b1; req0 = 0; req1 = 0; data0 = '0; data1 = '0; out_ready = 0;
    model_reset();
    #2;
    check_all();
    @(posedge clk);
    #1;
    reset = 1'b0;

    // Single beat from requester 0.
    cycle(1, 0, 32'hAAAAAAAA, 32'h0, 1);
    cycle(1, 0, 32'hAAAAAAAA, 32'h0, 1);
    cycle(0, 0, 32'hAAAAAAAA, 32'h0, 1);
    cycle(0, 0, 32'h0, 32'h0, 1);

    // Both requesting continuously: alternating bursts.
    for (int i = 0; i < 20; i++)
      cycle(1, 1, 32'h0000_0100 + 32'(i), 32'h1000_0100 + 32'(i), 1);

    // Reset mid-burst with the output slot full, then tie goes to requester 0.
    async_reset_mid_cycle();
    for (int i = 0; i < 6; i++)
      cycle(1, 1, 32'h0000_0200 + 32'(i), 32'h1000_0200 + 32'(i), 1);

    // Back-pressure while in G1.
    cycle(0, 0, 32'h0, 32'h0, 1);
    cycle(0, 0, 32'h0, 32'h0, 1);
    cycle(0, 1, 32'h0, 32'hB0B0_0001, 1);
    cycle(0, 1, 32'h0, 32'hB0B0_0001, 1);
    for (int i = 0; i < 3; i++) cycle(0, 1, 32'h0, 32'hB0B0_0002, 0);
    cycle(0, 1, 32'h0, 32'hB0B0_0002, 1);

    // Drop req0 after two beats while req1 waits.
    cycle(0, 0, 32'h0, 32'h0, 1);
    cycle(0, 0, 32'h0, 32'h0, 1);
    cycle(1, 1, 32'hC0C0_0001, 32'hD0D0_0001, 1);
    cycle(1, 1, 32'hC0C0_0001, 32'hD0D0_0001, 1);
    cycle(1, 1, 32'hC0C0_0002, 32'hD0D0_0001, 1);
    cycle(0, 1, 32'h0, 32'hD0D0_0001, 0);
    cycle(0, 1, 32'h0, 32'hD0D0_0001, 0);
    cycle(0, 1, 32'h0, 32'hD0D0_0001, 1);

    // Only requester 1: back-to-back re-grants.
    for (int i = 0; i < 14; i++)
      cycle(0, 1, 32'h0, 32'hE0E0_0000 + 32'(i), 1);

    // Random traffic; payload only changes after acceptance or while idle.
    d0 = $urandom; d1 = $urandom; r0 = 0; r1 = 0;
    for (int i = 0; i < 1500; i++) begin
      if (!r0 || m_acc0) d0 = $urandom;
      if (!r1 || m_acc1) d1 = $urandom;
      r0  = ($urandom_range(0, 3) != 0);
      r1  = ($urandom_range(0, 3) != 0);
      rdy = ($urandom_range(0, 9) < 7);
      cycle(r0, r1, d0, d1, rdy);
      if (i == 700) async_reset_mid_cycle();
    end

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule

// File: doc/mux32_arbiter.md
MUX32_ARBITER -- requirements
Module: mux32_arbiter

Interface
REQ-001 Parameter BURST_MAX, default 4: maximum accepted beats per grant before forced re-arbitration; legal range 1..15.
REQ-002 clk  input  1  single clock; all state updates on its rising edge.
REQ-003 reset  input  1  reset is asynchronous and active-high.
REQ-004 req0, req1  input  1 each  requester 0/1 has a beat pending.
REQ-005 data0, data1  input  32 each  requester 0/1 beat payload, stable while its req is high.
REQ-006 gnt0, gnt1  output  1 each  registered one-hot-or-zero grant.
REQ-007 sel  output  1  32-bit 2:1 mux select; 0 routes data0, 1 routes data1.
REQ-008 ack0, ack1  output  1 each  combinational pulse: the requester's current beat is accepted this cycle.
REQ-009 out_data  output  32  registered muxed payload.
REQ-010 out_valid  output  1  out_data holds an undelivered beat.
REQ-011 out_ready  input  1  downstream consumes out_data when out_valid and out_ready are both high.

Function
REQ-012 States: IDLE (no grant), G0 (gnt0=1, sel=0), G1 (gnt1=1, sel=1); sel holds its last value in IDLE.
REQ-013 Accept condition in Gx: req_x=1 and (out_valid=0 or out_ready=1); ack_x = accept condition; ack never asserts in IDLE.
REQ-014 On accept: out_data <= data_x via the sel-driven mux, out_valid <= 1, beat_cnt <= beat_cnt+1; latency from ack to out_valid is one clock.
REQ-015 Accept and drain in the same cycle: out_valid stays 1 and out_data takes the new beat; no beat is lost or duplicated.
REQ-016 Drain without accept: out_valid <= 0; out_data holds its value.
REQ-017 out_valid=1 and out_ready=0: out_data and out_valid hold; no accept (back-pressure).
REQ-018 last_grant records the requester most recently granted; it updates on every entry into G0 or G1.
REQ-019 Arbitration, evaluated in IDLE and at every grant release: one request -> grant it; both -> grant the requester not equal to last_grant; none -> IDLE.
REQ-020 Grant release in Gx occurs when req_x=0 at the clock edge, or when the accept in this cycle makes beat_cnt reach BURST_MAX.
REQ-021 On release, the next state is chosen per REQ-019 in the same edge (Gx -> Gy directly, no IDLE bubble); if only req_x remains, re-grant x with beat_cnt cleared.
REQ-022 beat_cnt (4 bits) clears on every grant entry and in IDLE; it never exceeds BURST_MAX.
REQ-023 A requester dropping req mid-grant loses no accepted beat; out_valid/out_data are unaffected by grant changes.
REQ-024 gnt0 and gnt1 are never high together; sel always equals gnt1 when any grant is active.

Reset
REQ-025 Reset assertion, including mid-burst, immediately forces state=IDLE, gnt0=gnt1=0, sel=0, out_valid=0, out_data=32'h0, beat_cnt=0, last_grant=1 (requester 0 wins the first tie); ack0=ack1=0 while reset is high.
REQ-026 After reset deasserts, the first arbitration occurs on the first rising edge with a request pending.

Verification
REQ-027 Reset, then req0=1, data0=32'hAAAAAAAA, out_ready=1 -> gnt0=1, sel=0 next edge; ack0 that cycle; out_data=32'hAAAAAAAA, out_valid=1 one edge later.
REQ-028 req0=req1=1 held, out_ready=1, BURST_MAX=4 -> grants alternate G0 (4 acks), G1 (4 acks), G0...; no IDLE cycle between bursts; requester 0 first.
REQ-029 In G1 with out_valid=1, hold out_ready=0 for 3 cycles -> ack1=0, out_data stable for those cycles; on out_ready=1 the beat drains and ack1 pulses in that same cycle.
REQ-030 In G0 after 2 beats drop req0 with req1=1 -> next edge G1, beat_cnt=0; last out_data remains the second data0 beat until drained.
REQ-031 Assert reset mid-burst with out_valid=1 -> out_valid=0, gnt0=gnt1=0 immediately (asynchronously); after release with req0=req1=1, requester 0 is granted first.
REQ-032 Only req1=1 continuously with out_ready=1 -> G1 re-granted after each BURST_MAX beats with no gap; ack1 high every cycle.
